// File: rtl/led_pkg.sv
// Shared encodings for the LED colour sequencer: step modes and step directions.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'b00,
        MODE_EDGE     = 2'b01,
        MODE_AUTO     = 2'b10,
        MODE_PINGPONG = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-run filter for a raw board push-button.
// btn_out follows btn_in DEBOUNCE_CYCLES+2 edges after a clean change; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          btn_db;
    logic [CW-1:0] stable_cnt;

    // The run counter only advances while the synchronised input disagrees with the filtered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            btn_db     <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (sync2 != btn_db) begin
                if (stable_cnt == CNT_MAX) begin
                    btn_db     <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign btn_out = btn_db;

endmodule

// File: rtl/led_sequencer.sv
// Multi-mode LED colour sequencer stepping FIRST..LAST from a debounced button.
// First HOLD/EDGE step lands DEBOUNCE_CYCLES+3 edges after the press; no backpressure.
module led_sequencer
    import led_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int FIRST           = 1,
    parameter int LAST            = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] colour,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] C_FIRST  = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] C_LAST   = WIDTH'(LAST);
    localparam int               AW       = $clog2(AUTO_PERIOD);
    localparam logic [AW-1:0]    AUTO_MAX = AW'(AUTO_PERIOD - 1);

    mode_e            mode_sel;
    logic             btn_db;
    logic             btn_db_q;
    logic             step;
    logic [AW-1:0]    auto_cnt;
    logic [AW-1:0]    auto_nxt;
    logic             pp_dir;
    logic             pp_dir_nxt;
    logic [WIDTH-1:0] colour_r;
    logic [WIDTH-1:0] colour_nxt;
    logic             wrap_r;
    logic             wrap_nxt;

    assign mode_sel = mode_e'(mode);

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_in (button),
        .btn_out(btn_db)
    );

    always_comb begin
        step     = 1'b0;
        auto_nxt = '0;
        case (mode_sel)
            MODE_HOLD:     step = btn_db;
            MODE_EDGE:     step = btn_db & ~btn_db_q;
            MODE_AUTO: begin
                step = btn_db && (auto_cnt == AUTO_MAX);
                if (btn_db) begin
                    auto_nxt = (auto_cnt == AUTO_MAX) ? '0 : auto_cnt + AW'(1);
                end
            end
            MODE_PINGPONG: step = btn_db;
            default:       step = 1'b0;
        endcase
    end

    // Outside PINGPONG the bounce direction shadows dir so entry starts the requested way.
    always_comb begin
        colour_nxt = colour_r;
        wrap_nxt   = 1'b0;
        pp_dir_nxt = (mode_sel == MODE_PINGPONG) ? pp_dir : dir;
        if (colour_r < C_FIRST || colour_r > C_LAST) begin
            colour_nxt = C_FIRST;
        end else if (step) begin
            if (mode_sel == MODE_PINGPONG) begin
                if (pp_dir == DIR_UP) begin
                    if (colour_r == C_LAST) begin
                        pp_dir_nxt = DIR_DOWN;
                        wrap_nxt   = 1'b1;
                    end else begin
                        colour_nxt = colour_r + WIDTH'(1);
                        if (colour_r + WIDTH'(1) == C_LAST) begin
                            pp_dir_nxt = DIR_DOWN;
                            wrap_nxt   = 1'b1;
                        end
                    end
                end else begin
                    if (colour_r == C_FIRST) begin
                        pp_dir_nxt = DIR_UP;
                        wrap_nxt   = 1'b1;
                    end else begin
                        colour_nxt = colour_r - WIDTH'(1);
                        if (colour_r - WIDTH'(1) == C_FIRST) begin
                            pp_dir_nxt = DIR_UP;
                            wrap_nxt   = 1'b1;
                        end
                    end
                end
            end else if (dir == DIR_UP) begin
                if (colour_r == C_LAST) begin
                    colour_nxt = C_FIRST;
                    wrap_nxt   = 1'b1;
                end else begin
                    colour_nxt = colour_r + WIDTH'(1);
                end
            end else begin
                if (colour_r == C_FIRST) begin
                    colour_nxt = C_LAST;
                    wrap_nxt   = 1'b1;
                end else begin
                    colour_nxt = colour_r - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_r <= C_FIRST;
            wrap_r   <= 1'b0;
            auto_cnt <= '0;
            pp_dir   <= DIR_UP;
            btn_db_q <= 1'b0;
        end else begin
            colour_r <= colour_nxt;
            wrap_r   <= wrap_nxt;
            auto_cnt <= auto_nxt;
            pp_dir   <= pp_dir_nxt;
            btn_db_q <= btn_db;
        end
    end

    assign colour = colour_r;
    assign wrap   = wrap_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_led_sequencer;

    localparam int WIDTH           = 3;
    localparam int FIRST           = 1;
    localparam int LAST            = 6;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int AUTO_PERIOD     = 16;
    localparam int N_COL           = LAST - FIRST + 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             button = 1'b0;
    logic [1:0]       mode   = 2'b00;
    logic             dir    = 1'b0;
    logic [WIDTH-1:0] colour;
    logic             wrap;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_s1 = 0, m_s2 = 0, m_db = 0, m_dbq = 0, m_run = 0, m_acnt = 0, m_pos = 0;
    int m_colour = FIRST;
    bit m_wrap = 1'b0, m_ppup = 1'b1, m_stp = 1'b0;
    int inj_req = 0, inj_seen = 0, inj_val = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .WIDTH(WIDTH), .FIRST(FIRST), .LAST(LAST),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .mode(mode), .dir(dir),
        .colour(colour), .wrap(wrap)
    );

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_s1 = 0; m_s2 = 0; m_db = 0; m_dbq = 0; m_run = 0; m_acnt = 0;
                m_colour = FIRST; m_wrap = 1'b0; m_ppup = 1'b1;
            end else begin
                if (inj_req != inj_seen) begin
                    m_colour = inj_val;
                    inj_seen = inj_req;
                end
                case (mode)
                    2'b01:   m_stp = (m_db == 1) && (m_dbq == 0);
                    2'b10:   m_stp = (m_db == 1) && (m_acnt == AUTO_PERIOD - 1);
                    default: m_stp = (m_db == 1);
                endcase
                m_acnt = (mode == 2'b10 && m_db == 1) ? (m_acnt + 1) % AUTO_PERIOD : 0;
                m_dbq  = m_db;
                if (m_s2 != m_db) begin
                    m_run++;
                    if (m_run >= DEBOUNCE_CYCLES) begin
                        m_db  = m_s2;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_s2 = m_s1;
                m_s1 = int'(button);
                m_wrap = 1'b0;
                if (m_colour < FIRST || m_colour > LAST) begin
                    m_colour = FIRST;
                end else if (m_stp) begin
                    if (mode != 2'b11) begin
                        m_pos = m_colour - FIRST;
                        if (dir == 1'b0) begin
                            m_wrap   = (m_pos == N_COL - 1);
                            m_colour = FIRST + (m_pos + 1) % N_COL;
                        end else begin
                            m_wrap   = (m_pos == 0);
                            m_colour = FIRST + (m_pos + N_COL - 1) % N_COL;
                        end
                    end else if (m_ppup && m_colour == LAST) begin
                        m_ppup = 1'b0; m_wrap = 1'b1;
                    end else if (!m_ppup && m_colour == FIRST) begin
                        m_ppup = 1'b1; m_wrap = 1'b1;
                    end else begin
                        m_colour = m_ppup ? m_colour + 1 : m_colour - 1;
                        if ((m_ppup && m_colour == LAST) || (!m_ppup && m_colour == FIRST)) begin
                            m_ppup = !m_ppup; m_wrap = 1'b1;
                        end
                    end
                end
                if (mode != 2'b11) m_ppup = (dir == 1'b0);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; button = 1'b0; mode = 2'b00; dir = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (colour !== WIDTH'(FIRST)) begin miscompares++; $display("FAIL reset_colour: got %0d expected %0d", colour, FIRST); end
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
        rst = 1'b0; button = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (colour !== WIDTH'(3)) begin miscompares++; $display("FAIL pre_async_colour: got %0d expected 3", colour); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (colour !== WIDTH'(FIRST)) begin miscompares++; $display("FAIL async_reset_colour: got %0d expected %0d", colour, FIRST); end
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL async_reset_wrap: got %0b expected 0", wrap); end
        @(negedge clk);
        rst = 1'b0; button = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold();
        int exp_c;
        mode = 2'b00; dir = 1'b0; button = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            exp_c = (e < 7 || e == 12) ? FIRST : e - 5;
            vectors++;
            if (int'(colour) !== exp_c) begin miscompares++; $display("FAIL hold_colour edge %0d: got %0d expected %0d", e, colour, exp_c); end
            vectors++;
            if (wrap !== (e == 12)) begin miscompares++; $display("FAIL hold_wrap edge %0d: got %0b expected %0b", e, wrap, e == 12); end
        end
        button = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (colour !== WIDTH'(FIRST)) begin miscompares++; $display("FAIL hold_release_colour: got %0d expected %0d", colour, FIRST); end
        repeat (5) @(negedge clk);
        vectors++;
        if (colour !== WIDTH'(FIRST) || wrap !== 1'b0) begin miscompares++; $display("FAIL hold_idle: got %0d/%0b expected %0d/0", colour, wrap, FIRST); end
    endtask

    task automatic test_edge();
        int wraps, exp_c;
        mode = 2'b01; dir = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wraps = 0;
            button = 1'b1;
            repeat (10) begin @(negedge clk); if (wrap) wraps++; end
            button = 1'b0;
            repeat (10) begin @(negedge clk); if (wrap) wraps++; end
            exp_c = (p == 0) ? LAST : LAST - p;
            vectors++;
            if (int'(colour) !== exp_c) begin miscompares++; $display("FAIL edge_press%0d_colour: got %0d expected %0d", p, colour, exp_c); end
            vectors++;
            if (wraps !== ((p == 0) ? 1 : 0)) begin miscompares++; $display("FAIL edge_press%0d_wraps: got %0d expected %0d", p, wraps, (p == 0) ? 1 : 0); end
        end
        button = 1'b1;
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (int'(colour) !== LAST - 2) begin miscompares++; $display("FAIL edge_glitch: got %0d expected %0d", colour, LAST - 2); end
    endtask

    task automatic test_auto();
        int nchg;
        int chg_edge [3];
        logic [WIDTH-1:0] prev;
        mode = 2'b10; dir = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nchg = 0;
        for (int i = 0; i < 3; i++) chg_edge[i] = -1;
        prev = colour;
        button = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(negedge clk);
            if (colour !== prev) begin
                if (nchg < 3) chg_edge[nchg] = e;
                nchg++;
                prev = colour;
            end
        end
        vectors++;
        if (nchg !== 3) begin miscompares++; $display("FAIL auto_step_count: got %0d expected 3", nchg); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (chg_edge[i] !== 22 + 16 * i) begin miscompares++; $display("FAIL auto_step%0d_edge: got %0d expected %0d", i, chg_edge[i], 22 + 16 * i); end
        end
        vectors++;
        if (int'(colour) !== FIRST + 3) begin miscompares++; $display("FAIL auto_final_colour: got %0d expected %0d", colour, FIRST + 3); end
        button = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_pingpong();
        int seq [12];
        int exp_c;
        seq = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2};
        mode = 2'b11; dir = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        button = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            exp_c = (e < 6) ? FIRST : seq[e - 6];
            vectors++;
            if (int'(colour) !== exp_c) begin miscompares++; $display("FAIL pp_colour edge %0d: got %0d expected %0d", e, colour, exp_c); end
            vectors++;
            if (wrap !== (e == 11 || e == 16)) begin miscompares++; $display("FAIL pp_wrap edge %0d: got %0b expected %0b", e, wrap, e == 11 || e == 16); end
            dir = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_recovery();
        mode = 2'b00; dir = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                force dut.colour_r = WIDTH'(0);
                inj_val = 0;
            end else begin
                force dut.colour_r = WIDTH'(2 ** WIDTH - 1);
                inj_val = 2 ** WIDTH - 1;
            end
            inj_req++;
            #1 release dut.colour_r;
            @(negedge clk);
            vectors++;
            if (colour !== WIDTH'(FIRST)) begin miscompares++; $display("FAIL recover%0d_colour: got %0d expected %0d", k, colour, FIRST); end
            vectors++;
            if (wrap !== 1'b0) begin miscompares++; $display("FAIL recover%0d_wrap: got %0b expected 0", k, wrap); end
        end
    endtask

    task automatic test_random();
        int hold_left;
        int r;
        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vectors++;
            if (int'(colour) !== m_colour) begin miscompares++; $display("FAIL rand_colour cycle %0d: got %0d expected %0d", c, colour, m_colour); end
            vectors++;
            if (wrap !== m_wrap) begin miscompares++; $display("FAIL rand_wrap cycle %0d: got %0b expected %0b", c, wrap, m_wrap); end
            if (hold_left == 0) begin
                button    = ~button;
                hold_left = $urandom_range(1, 24);
            end else begin
                hold_left--;
            end
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            r = $urandom_range(0, 399);
            if (r < 2) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_edge();
        test_auto();
        test_pingpong();
        test_recovery();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
